// File: rtl/fanout_broadcast_stage.sv
// fanout_broadcast_stage
//   Two-entry skid buffer that broadcasts each accepted word to NUM_LOADS
//   consumers. Every load sees the same head word on out_data and
//   acknowledges it on its own out_ready bit; the head retires once all
//   loads have taken it, whether together or on different cycles.
//
// Parameters
//   WIDTH      data width in bits
//   NUM_LOADS  number of broadcast consumers (1..8)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream word present
//   in_ready   stage can accept a word (registered state only)
//   in_data    upstream word
//   out_valid  per-load valid, bit i for load i
//   out_ready  per-load accept, bit i for load i
//   out_data   head word, shared by all loads
//   stall_cnt  saturating count of cycles with in_valid=1 and in_ready=0
//              (present only when FANOUT_BROADCAST_STAGE_STALL_CNT_EN is defined)
module fanout_broadcast_stage #(
    parameter int WIDTH     = 8,
    parameter int NUM_LOADS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic [NUM_LOADS-1:0] out_valid,
    input  logic [NUM_LOADS-1:0] out_ready,
    output logic [WIDTH-1:0]     out_data
`ifdef FANOUT_BROADCAST_STAGE_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]           state;
    logic [WIDTH-1:0]     head_data;
    logic [WIDTH-1:0]     tail_data;
    logic [NUM_LOADS-1:0] served;
    // Held low through reset so in_ready rises only on the first edge after release.
    logic                 ready_en;

    logic                 push;
    logic                 retire;
    logic [NUM_LOADS-1:0] handshake;

    assign in_ready  = ready_en && (state != TWO);
    assign out_valid = (state != EMPTY) ? ~served : '0;
    assign out_data  = head_data;
    assign handshake = out_valid & out_ready;
    assign push      = in_valid && in_ready;
    // A load already served counts as done even if it has dropped out_ready.
    assign retire    = (state != EMPTY) && (&(served | out_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            head_data <= '0;
            tail_data <= '0;
            served    <= '0;
            ready_en  <= 1'b0;
        end else begin
            ready_en <= 1'b1;

            if (retire) begin
                served <= '0;
            end else begin
                served <= served | handshake;
            end

            case (state)
                EMPTY: begin
                    if (push) begin
                        head_data <= in_data;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (push && retire) begin
                        // Outgoing head leaves as the new word lands: new word becomes head.
                        head_data <= in_data;
                    end else if (push) begin
                        tail_data <= in_data;
                        state     <= TWO;
                    end else if (retire) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (retire) begin
                        head_data <= tail_data;
                        state     <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

`ifdef FANOUT_BROADCAST_STAGE_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fanout_broadcast_stage.sv
// Testbench for fanout_broadcast_stage (WIDTH=8, NUM_LOADS=3).
// A transaction-level model (word queue plus per-load served bits) predicts
// in_ready, out_valid and out_data each cycle; directed scenarios add fixed
// expected values at key points.
module tb_fanout_broadcast_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] out_valid;
    logic [2:0] out_ready;
    logic [7:0] out_data;
`ifdef FANOUT_BROADCAST_STAGE_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int tests;
    int fails;

    // Reference model state
    logic [7:0] q[$];
    logic [2:0] m_served;
    logic       m_rdy_en;

    fanout_broadcast_stage #(.WIDTH(8), .NUM_LOADS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FANOUT_BROADCAST_STAGE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock cycle: drive inputs, compare against the model, advance the model at the edge.
    task automatic step(input logic iv, input logic [7:0] d, input logic [2:0] ordy);
        logic       exp_rdy;
        logic [2:0] exp_vld;
        logic [2:0] hs;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_rdy = m_rdy_en && (q.size() < 2);
        exp_vld = (q.size() > 0) ? ~m_served : 3'b000;
        tests++;
        if (in_ready !== exp_rdy) begin
            fails++;
            $display("FAIL model_in_ready t=%0t got %b want %b", $time, in_ready, exp_rdy);
        end
        tests++;
        if (out_valid !== exp_vld) begin
            fails++;
            $display("FAIL model_out_valid t=%0t got %b want %b", $time, out_valid, exp_vld);
        end
        if (q.size() > 0) begin
            tests++;
            if (out_data !== q[0]) begin
                fails++;
                $display("FAIL model_out_data t=%0t got %h want %h", $time, out_data, q[0]);
            end
        end
        @(posedge clk);
        hs = exp_vld & ordy;
        if ((q.size() > 0) && (&(m_served | hs))) begin
            void'(q.pop_front());
            m_served = 3'b000;
        end else begin
            m_served = m_served | hs;
        end
        if (iv && exp_rdy) q.push_back(d);
        m_rdy_en = 1'b1;
        #1;
    endtask

    task automatic expect_outs(input string name, input logic [2:0] vld, input logic [7:0] dat,
                               input logic chk_dat);
        tests++;
        if (out_valid !== vld) begin
            fails++;
            $display("FAIL %s_valid got %b want %b", name, out_valid, vld);
        end
        if (chk_dat) begin
            tests++;
            if (out_data !== dat) begin
                fails++;
                $display("FAIL %s_data got %h want %h", name, out_data, dat);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = '0;
        q.delete(); m_served = '0; m_rdy_en = 1'b0;
        #1;
        tests++;
        if (out_valid !== 3'b000 || in_ready !== 1'b0 || out_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs got vld=%b rdy=%b data=%h want 000 0 00",
                     out_valid, in_ready, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, 8'h00, 3'b000);   // in_ready must still be 0 before the first edge
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_single_word();
        step(1'b1, 8'hA5, 3'b111);
        expect_outs("single", 3'b111, 8'hA5, 1'b1);
        step(1'b0, 8'h00, 3'b111);
        expect_outs("single_retired", 3'b000, 8'h00, 1'b0);
        step(1'b0, 8'h00, 3'b000);
    endtask

    task automatic test_staggered();
        step(1'b1, 8'h3C, 3'b000);
        expect_outs("stag0", 3'b111, 8'h3C, 1'b1);
        step(1'b0, 8'h00, 3'b001);
        expect_outs("stag1", 3'b110, 8'h3C, 1'b1);
        step(1'b0, 8'h00, 3'b100);
        expect_outs("stag2", 3'b010, 8'h3C, 1'b1);
        step(1'b0, 8'h00, 3'b010);
        expect_outs("stag3", 3'b000, 8'h00, 1'b0);
    endtask

    task automatic test_backpressure();
        step(1'b1, 8'h01, 3'b000);
        step(1'b1, 8'h02, 3'b000);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_in_ready got %b want 0", in_ready);
        end
        step(1'b1, 8'h03, 3'b000);
        step(1'b1, 8'h03, 3'b000);
        expect_outs("bp_head1", 3'b111, 8'h01, 1'b1);
        step(1'b1, 8'h03, 3'b111);
        expect_outs("bp_head2", 3'b111, 8'h02, 1'b1);
        step(1'b1, 8'h03, 3'b111);
        expect_outs("bp_head3", 3'b111, 8'h03, 1'b1);
        step(1'b0, 8'h00, 3'b111);
        step(1'b0, 8'h00, 3'b000);
    endtask

    task automatic test_push_retire();
        step(1'b1, 8'h10, 3'b000);
        step(1'b1, 8'h20, 3'b111);
        expect_outs("pushret", 3'b111, 8'h20, 1'b1);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL pushret_in_ready got %b want 1", in_ready);
        end
        step(1'b0, 8'h00, 3'b111);
        step(1'b0, 8'h00, 3'b000);
    endtask

    task automatic test_reset_mid();
        step(1'b1, 8'hAA, 3'b000);
        step(1'b1, 8'hBB, 3'b101);
        expect_outs("mid_pre", 3'b010, 8'hAA, 1'b1);
        rst_n = 1'b0;
        q.delete(); m_served = '0; m_rdy_en = 1'b0;
        #1;
        tests++;
        if (out_valid !== 3'b000 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset got vld=%b rdy=%b want 000 0", out_valid, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, 8'h00, 3'b111);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 3'b000) begin
            fails++;
            $display("FAIL mid_release got rdy=%b vld=%b want 1 000", in_ready, out_valid);
        end
        step(1'b0, 8'h00, 3'b111);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 3'b111);
    endtask

`ifdef FANOUT_BROADCAST_STAGE_STALL_CNT_EN
    task automatic test_stall_cnt();
        in_valid = 1'b1; in_data = 8'h55; out_ready = 3'b000;
        repeat (70000) @(posedge clk);
        #1;
        tests++;
        if (stall_cnt !== 16'hFFFF) begin
            fails++;
            $display("FAIL stall_cnt_sat got %h want ffff", stall_cnt);
        end
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single_word();
        test_staggered();
        test_backpressure();
        test_push_retire();
        test_reset_mid();
        test_random();
`ifdef FANOUT_BROADCAST_STAGE_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
